// File: rtl/fp_div_pkg.sv
// ----------------------------------------------------------------------------
// fp_div_pkg: shared types, flag indices and width helpers for fp_seq_divider.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fp_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } div_state_t;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    NORMAL = 2'd1,
    INF    = 2'd2,
    NAN    = 2'd3
  } fp_class_t;

  localparam int FLG_INV = 3;
  localparam int FLG_DZ  = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;

  function automatic int word_w(input int exp_w, input int frac_w);
    return 1 + exp_w + frac_w;
  endfunction

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int rem_w(input int frac_w);
    return 2 * frac_w + 4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_div_classify.sv
// ----------------------------------------------------------------------------
// fp_div_classify: splits an FP word into sign/exponent/hidden-bit mantissa
// and class; subnormals are flushed to ZERO.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fp_div_classify
  import fp_div_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic [EXP_W+FRAC_W:0] x,
  output logic                  sign,
  output logic [EXP_W-1:0]      expo,
  output logic [FRAC_W:0]       mant,
  output fp_class_t             cls
);

  always_comb begin
    sign = x[EXP_W+FRAC_W];
    expo = x[FRAC_W +: EXP_W];
    mant = {1'b1, x[FRAC_W-1:0]};
    if (expo == '0) begin
      cls = ZERO;
    end else if (&expo) begin
      cls = (x[FRAC_W-1:0] == '0) ? INF : NAN;
    end else begin
      cls = NORMAL;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_seq_divider.sv
// ----------------------------------------------------------------------------
// fp_seq_divider: multi-cycle restoring radix-2 FP divider, Out = A / B.
// Optional round-to-nearest-even via macro FP_DIV_ROUND_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fp_seq_divider
  import fp_div_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] A,
  input  logic [EXP_W+FRAC_W:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] Out,
  output logic [3:0]            flags
);

  localparam int W    = word_w(EXP_W, FRAC_W);
  localparam int BIAS = exp_bias(EXP_W);
  localparam int RW   = rem_w(FRAC_W);
  localparam int QW   = FRAC_W + 3;
  localparam int CW   = $clog2(QW);
  localparam int XW   = EXP_W + 2;

  localparam logic [CW-1:0]        CNT_LAST = CW'(QW - 1);
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  div_state_t state, state_nxt;

  logic                  sa, sb;
  logic [EXP_W-1:0]      ea, eb;
  logic [FRAC_W:0]       ma, mb;
  fp_class_t             ca, cb;

  logic                  accept;
  logic                  special;
  logic                  sign_r;
  logic [W-1:0]          sp_word;
  logic [3:0]            sp_flags;

  logic                  sign_q;
  logic signed [XW-1:0]  exp_base;
  logic [RW-1:0]         rem;
  logic [RW-1:0]         dvs;
  logic [QW-1:0]         quo;
  logic [CW-1:0]         cnt;
  logic                  rem_ge;

  logic                  q_msb;
  logic [FRAC_W:0]       mant_full;
  logic signed [XW-1:0]  exp_pre;
  logic [FRAC_W-1:0]     nrm_frac;
  logic signed [XW-1:0]  nrm_exp;
  logic [W-1:0]          nrm_word;
  logic [3:0]            nrm_flags;

  fp_div_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_a (
    .x    (A),
    .sign (sa),
    .expo (ea),
    .mant (ma),
    .cls  (ca)
  );

  fp_div_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_b (
    .x    (B),
    .sign (sb),
    .expo (eb),
    .mant (mb),
    .cls  (cb)
  );

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign special  = !((ca == NORMAL) && (cb == NORMAL));
  assign sign_r   = sa ^ sb;

  // Priority matters: NaN beats everything, inf/0 is inf without div_by_zero.
  always_comb begin
    sp_word  = {sign_r, {(W-1){1'b0}}};
    sp_flags = '0;
    if ((ca == NAN) || (cb == NAN)) begin
      sp_word = QNAN;
    end else if (((ca == ZERO) && (cb == ZERO)) || ((ca == INF) && (cb == INF))) begin
      sp_word           = QNAN;
      sp_flags[FLG_INV] = 1'b1;
    end else if (ca == INF) begin
      sp_word = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (cb == ZERO) begin
      sp_word          = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      sp_flags[FLG_DZ] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : DIV;
      DIV:     if (cnt == CNT_LAST) state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rem_ge = (rem >= dvs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q    <= 1'b0;
      exp_base  <= '0;
      rem       <= '0;
      dvs       <= '0;
      quo       <= '0;
      cnt       <= '0;
      Out       <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign_q   <= sign_r;
            exp_base <= {2'b00, ea} - {2'b00, eb} + XW'(BIAS);
            // Both mantissas sit aligned at the top so the first compare yields the integer bit.
            rem      <= {{(RW-FRAC_W-1){1'b0}}, ma} << (FRAC_W + 2);
            dvs      <= {{(RW-FRAC_W-1){1'b0}}, mb} << (FRAC_W + 2);
            quo      <= '0;
            cnt      <= '0;
            if (special) begin
              Out   <= sp_word;
              flags <= sp_flags;
            end
          end
        end
        DIV: begin
          rem <= rem_ge ? (rem - dvs) : rem;
          dvs <= dvs >> 1;
          quo <= {quo[QW-2:0], rem_ge};
          if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end
        end
        NORM: begin
          Out   <= nrm_word;
          flags <= nrm_flags;
        end
        DONE: begin
          out_valid <= !(out_valid && out_ready);
        end
        default: ;
      endcase
    end
  end

  // Quotient lies in (0.5, 2); a clear MSB means one left shift is needed.
  always_comb begin
    q_msb     = quo[QW-1];
    mant_full = q_msb ? quo[QW-1:2] : quo[QW-2:1];
    exp_pre   = exp_base - {{(XW-1){1'b0}}, ~q_msb};
  end

`ifdef FP_DIV_ROUND_EN
  logic                guard;
  logic                sticky;
  logic                round_up;
  logic [FRAC_W+1:0]   mant_rnd;

  always_comb begin
    guard    = q_msb ? quo[1] : quo[0];
    sticky   = (q_msb & quo[0]) | (|rem);
    round_up = guard & (sticky | mant_full[0]);
    mant_rnd = {1'b0, mant_full} + {{(FRAC_W+1){1'b0}}, round_up};
    if (mant_rnd[FRAC_W+1]) begin
      nrm_frac = mant_rnd[FRAC_W:1];
      nrm_exp  = exp_pre + {{(XW-1){1'b0}}, 1'b1};
    end else begin
      nrm_frac = mant_rnd[FRAC_W-1:0];
      nrm_exp  = exp_pre;
    end
  end
`else
  logic unused_trunc;
  assign unused_trunc = ^{quo[0], mant_full[FRAC_W]};

  always_comb begin
    nrm_frac = mant_full[FRAC_W-1:0];
    nrm_exp  = exp_pre;
  end
`endif

  always_comb begin
    nrm_word  = {sign_q, nrm_exp[EXP_W-1:0], nrm_frac};
    nrm_flags = '0;
    if (nrm_exp >= EXP_MAX) begin
      nrm_word           = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      nrm_flags[FLG_OVF] = 1'b1;
    end else if (nrm_exp[XW-1] || (nrm_exp == '0)) begin
      nrm_word           = {sign_q, {(W-1){1'b0}}};
      nrm_flags[FLG_UNF] = 1'b1;
    end
  end

endmodule

`default_nettype wire
